uart_transmitter: RTL and testbench

- Byte-serial UART transmitter, 8N1 format, LSB first. It is the transmit-side counterpart of the programmer UART receiver.
- Carries ICCM-programmer responses and acks, or debug bytes, back to the host over a dedicated TX pin.
- A small byte FIFO decouples the producer from line timing. Bit period is set at runtime through a clocks-per-bit input, matching the receiver's baud setting.

---
 rtl/uart_transmitter.sv | 105 ++++++++++
 tb/tb_uart_transmitter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 LSB-first UART transmitter fed by a small byte FIFO.
// Bit period is latched per frame from clks_per_bit_i at pop time.
module uart_transmitter #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [15:0]   clks_per_bit_i,
    input  logic          tx_valid_i,
    input  logic [7:0]    tx_byte_i,
    output logic          tx_ready_o,
    output logic          tx_serial_o,
    output logic          tx_active_o,
    output logic          tx_done_o,
    output logic [LW-1:0] fifo_level_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        r_state, w_state_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_shift, w_shift_next;
    logic [15:0]   r_cpb, w_cpb_next, r_cnt, w_cnt_next;
    logic [2:0]    r_bit, w_bit_next;
    logic          r_serial, r_done, w_serial_next;
    logic          w_push, w_pop, w_last, w_empty;

    assign w_empty      = r_level == '0;
    assign tx_ready_o   = r_level != LW'(DEPTH);
    assign w_push       = tx_valid_i && tx_ready_o;
    assign w_last       = r_cnt == r_cpb - 16'd1;
    assign tx_serial_o  = r_serial;
    assign tx_active_o  = r_state != IDLE;
    assign tx_done_o    = r_done;
    assign fifo_level_o = r_level;

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cpb_next   = r_cpb;
        w_bit_next   = r_bit;
        w_cnt_next   = (r_state == IDLE) ? 16'd0 : r_cnt + 16'd1;
        case (r_state)
            IDLE:  ;
            START: if (w_last) begin
                w_state_next = DATA;
                w_cnt_next   = '0;
                w_bit_next   = '0;
            end
            DATA:  if (w_last) begin
                w_cnt_next   = '0;
                w_shift_next = r_shift >> 1;
                w_bit_next   = r_bit + 3'd1;
                w_state_next = (r_bit == 3'd7) ? STOP : DATA;
            end
            STOP:  if (w_last) begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
        // Popping from STOP chains frames with no idle gap.
        w_pop = !w_empty && (r_state == IDLE || (r_state == STOP && w_last));
        if (w_pop) begin
            w_shift_next = r_mem[r_rd_ptr];
            w_cpb_next   = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
            w_cnt_next   = '0;
            w_state_next = START;
        end
        // The line register follows the upcoming state so it lines up with it.
        w_serial_next = (w_state_next == START) ? 1'b0 :
                        (w_state_next == DATA)  ? w_shift_next[0] : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_shift  <= '0;
            r_cpb    <= 16'd1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_level  <= r_level + LW'(w_push) - LW'(w_pop);
            r_shift  <= w_shift_next;
            r_cpb    <= w_cpb_next;
            r_cnt    <= w_cnt_next;
            r_bit    <= w_bit_next;
            r_serial <= w_serial_next;
            r_done   <= r_state == STOP && w_last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_byte_i;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of framing, FIFO flow, reset abort and baud latching.
module tb_uart_transmitter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] clks_per_bit_i = 16'd4;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_byte_i = 8'h00;
    logic        tx_ready_o, tx_serial_o, tx_active_o, tx_done_o;
    logic [2:0]  fifo_level_o;
    logic [7:0]  q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    uart_transmitter #(.DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .clks_per_bit_i(clks_per_bit_i),
        .tx_valid_i(tx_valid_i), .tx_byte_i(tx_byte_i), .tx_ready_o(tx_ready_o),
        .tx_serial_o(tx_serial_o), .tx_active_o(tx_active_o), .tx_done_o(tx_done_o),
        .fifo_level_o(fifo_level_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load();
        tx_valid_i = q.size() > 0;
        tx_byte_i  = q.size() > 0 ? q[0] : 8'h00;
    endtask

    // Advance to the next negedge, retiring the queued byte if it was accepted.
    task automatic tick();
        logic acc;
        acc = tx_valid_i && tx_ready_o && !rst_i;
        @(negedge clk);
        if (acc && q.size() > 0) void'(q.pop_front());
        load();
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input int cpb, input int skip);
        int errs = 0;
        logic e;
        for (int j = skip; j < 10 * cpb; j++) begin
            e = (j / cpb == 0) ? 1'b0 : (j / cpb == 9) ? 1'b1 : b[j / cpb - 1];
            if (tx_serial_o !== e || tx_active_o !== 1'b1) errs++;
            tick();
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        int errs;
        tick();
        tick();
        chk("rst_line", tx_serial_o, 1);
        chk("rst_ready", tx_ready_o, 1);
        chk("rst_active", tx_active_o, 0);
        chk("rst_done", tx_done_o, 0);
        chk("rst_level", fifo_level_o, 0);
        rst_i = 1'b0;
        tick();

        q = '{8'h55}; load();
        tick();
        chk("t1_level", fifo_level_o, 1);
        chk("t1_idle_line", tx_serial_o, 1);
        tick();
        check_frame("t1_frame", 8'h55, 4, 0);
        chk("t1_done", tx_done_o, 1);
        chk("t1_inactive", tx_active_o, 0);
        tick();
        chk("t1_done_once", tx_done_o, 0);

        clks_per_bit_i = 16'd3;
        q = '{8'hA5, 8'h0F, 8'hFF}; load();
        tick();
        chk("t2_level1", fifo_level_o, 1);
        tick();
        check_frame("t2_frame_a5", 8'hA5, 3, 0);
        chk("t2_done_a", tx_done_o, 1);
        chk("t2_level_after_pop", fifo_level_o, 1);
        check_frame("t2_frame_0f", 8'h0F, 3, 0);
        chk("t2_level_empty", fifo_level_o, 0);
        check_frame("t2_frame_ff", 8'hFF, 3, 0);
        chk("t2_done_c", tx_done_o, 1);
        chk("t2_idle", tx_active_o, 0);
        tick();

        clks_per_bit_i = 16'd8;
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}; load();
        tick();
        tick();
        repeat (3) tick();
        chk("t3_full_level", fifo_level_o, 4);
        chk("t3_full_ready", tx_ready_o, 0);
        check_frame("t3_frame_11", 8'h11, 8, 3);
        chk("t3_level_after_pop", fifo_level_o, 3);
        chk("t3_ready_again", tx_ready_o, 1);
        chk("t3_sixth_waiting", tx_valid_i, 1);
        check_frame("t3_frame_22", 8'h22, 8, 0);
        check_frame("t3_frame_33", 8'h33, 8, 0);
        check_frame("t3_frame_44", 8'h44, 8, 0);
        check_frame("t3_frame_55", 8'h55, 8, 0);
        check_frame("t3_frame_66", 8'h66, 8, 0);
        chk("t3_drained", fifo_level_o, 0);
        chk("t3_done", tx_done_o, 1);
        tick();

        clks_per_bit_i = 16'd4;
        q = '{8'hC3, 8'hAA, 8'hBB}; load();
        tick();
        tick();
        repeat (17) tick();
        chk("t4_bit3_line", tx_serial_o, 0);
        chk("t4_queued", fifo_level_o, 2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t4_line", tx_serial_o, 1);
        chk("t4_active", tx_active_o, 0);
        chk("t4_level", fifo_level_o, 0);
        chk("t4_ready", tx_ready_o, 1);
        chk("t4_done", tx_done_o, 0);
        errs = 0;
        repeat (60) begin
            tick();
            if (tx_serial_o !== 1'b1 || tx_active_o !== 1'b0 || tx_done_o !== 1'b0) errs++;
        end
        chk("t4_quiet", errs, 0);

        clks_per_bit_i = 16'd5;
        q = '{8'h5A, 8'h3C}; load();
        tick();
        tick();
        repeat (10) tick();
        clks_per_bit_i = 16'd2;
        check_frame("t5_frame_cpb5", 8'h5A, 5, 10);
        chk("t5_done_a", tx_done_o, 1);
        check_frame("t5_frame_cpb2", 8'h3C, 2, 0);
        chk("t5_done_b", tx_done_o, 1);
        chk("t5_idle", tx_active_o, 0);
        tick();

        clks_per_bit_i = 16'd0;
        q = '{8'h01}; load();
        tick();
        tick();
        check_frame("t6_frame_cpb0", 8'h01, 1, 0);
        chk("t6_done", tx_done_o, 1);
        chk("t6_idle", tx_active_o, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
